// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//   Packs bytes from the UART receiver into big-endian DATA_WIDTH words and
//   writes them to instruction memory over a valid/ready port. The CPU is
//   held in reset while loading and released when the receiver signals
//   end-of-transmission.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_byte, i_byte_valid received byte and its one-cycle strobe
//   i_clear_sign         end-of-transmission pulse
//   i_restart            re-arm from DONE
//   i_mem_ready          memory accepts the current write
//   o_mem_we/addr/wdata  write request, held until accepted
//   o_cpu_hold           1 while loading
//   o_load_done          load finished
//   o_word_count         words written so far
//   o_overrun            sticky, byte dropped (holding register full)
//   o_full_err           sticky, byte dropped (memory full)
//
// state   | meaning
// IDLE    | armed, waiting for the first byte; stray clear pulses ignored
// COLLECT | packing bytes into the word register
// WRITE   | write request outstanding; late bytes go to the holding register
// DONE    | load finished, CPU released; waits for restart
module uart_boot_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_byte,
  input  logic                  i_byte_valid,
  input  logic                  i_clear_sign,
  input  logic                  i_restart,
  input  logic                  i_mem_ready,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_cpu_hold,
  output logic                  o_load_done,
  output logic [ADDR_WIDTH:0]   o_word_count,
  output logic                  o_overrun,
  output logic                  o_full_err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CW    = $clog2(BYTES + 1);
  localparam logic [CW-1:0]         BYTES_C = CW'(BYTES);
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BASE_C  = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   wcount_q, wcount_d;
  logic                  hold_v_q, hold_v_d;
  logic [7:0]            hold_b_q, hold_b_d;
  logic                  fin_q, fin_d;
  logic                  ovr_q, ovr_d;
  logic                  ferr_q, ferr_d;

  logic                  full;
  logic                  take;
  logic                  fin_now;
  logic [7:0]            byte_src;
  logic [CW-1:0]         n_cnt;
  logic [DATA_WIDTH-1:0] n_word;

  assign full = (wcount_q == DEPTH_C);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      word_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      addr_q   <= BASE_C;
      wcount_q <= '0;
      hold_v_q <= 1'b0;
      hold_b_q <= '0;
      fin_q    <= 1'b0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wcount_q <= wcount_d;
      hold_v_q <= hold_v_d;
      hold_b_q <= hold_b_d;
      fin_q    <= fin_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wcount_d = wcount_q;
    hold_v_d = hold_v_q;
    hold_b_d = hold_b_q;
    fin_d    = fin_q;
    ovr_d    = ovr_q;
    ferr_d   = ferr_q;
    // A byte parked during WRITE takes priority over a live one; a live byte
    // arriving in the same cycle refills the holder.
    byte_src = hold_v_q ? hold_b_q : i_byte;
    take     = hold_v_q | i_byte_valid;
    n_cnt    = cnt_q;
    n_word   = word_q;
    fin_now  = 1'b0;

    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (take) begin
          if (hold_v_q) begin
            hold_v_d = i_byte_valid;
            if (i_byte_valid) hold_b_d = i_byte;
          end
          if (full) begin
            ferr_d = 1'b1;
          end else begin
            n_cnt  = cnt_q + CW'(1);
            n_word = (word_q << 8) | DATA_WIDTH'(byte_src);
          end
        end
        // In IDLE a clear only counts when it comes with the first byte.
        fin_now = (state_q == S_COLLECT || take) && (i_clear_sign || fin_q);
        if (!full && n_cnt == BYTES_C) begin
          state_d = S_WRITE;
          wdata_d = n_word;
          word_d  = '0;
          cnt_d   = '0;
          fin_d   = fin_now;
        end else if (fin_now) begin
          word_d = '0;
          cnt_d  = '0;
          if (full || n_cnt == '0) begin
            state_d = S_DONE;
            fin_d   = 1'b0;
          end else begin
            state_d = S_WRITE;
            wdata_d = n_word << (8 * (BYTES - int'(n_cnt)));
            fin_d   = 1'b1;
          end
        end else begin
          cnt_d  = n_cnt;
          word_d = n_word;
          if (take) state_d = S_COLLECT;
        end
      end
      S_WRITE: begin
        if (i_byte_valid) begin
          if (hold_v_q) begin
            ovr_d = 1'b1;
          end else begin
            hold_v_d = 1'b1;
            hold_b_d = i_byte;
          end
        end
        if (i_clear_sign) fin_d = 1'b1;
        if (i_mem_ready) begin
          addr_d   = addr_q + ADDR_WIDTH'(1);
          wcount_d = wcount_q + (ADDR_WIDTH + 1)'(1);
          if (fin_q || i_clear_sign) begin
            state_d = S_DONE;
            fin_d   = 1'b0;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_DONE: begin
        if (i_restart) begin
          state_d  = S_IDLE;
          word_d   = '0;
          cnt_d    = '0;
          addr_d   = BASE_C;
          wcount_d = '0;
          hold_v_d = 1'b0;
          fin_d    = 1'b0;
          ovr_d    = 1'b0;
          ferr_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_mem_we    = (state_q == S_WRITE);
    o_cpu_hold  = (state_q != S_DONE);
    o_load_done = (state_q == S_DONE);
  end

  assign o_mem_addr   = addr_q;
  assign o_mem_wdata  = wdata_q;
  assign o_word_count = wcount_q;
  assign o_overrun    = ovr_q;
  assign o_full_err   = ferr_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
module tb_uart_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        clear_sign;
  logic        restart;
  logic        mem_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic [8:0]  word_count;
  logic        overrun;
  logic        full_err;

  int vectors = 0;
  int miscompares = 0;

  logic [39:0] exp_q[$];

  always #5 clk = ~clk;

  uart_boot_loader #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .MEM_DEPTH(2), .BASE_ADDR(0)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_byte(byte_in), .i_byte_valid(byte_valid),
    .i_clear_sign(clear_sign), .i_restart(restart), .i_mem_ready(mem_ready),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_cpu_hold(cpu_hold), .o_load_done(load_done), .o_word_count(word_count),
    .o_overrun(overrun), .o_full_err(full_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted write and checks that a
  // stalled request does not change while it waits.
  logic        pend = 1'b0;
  logic [39:0] pend_v;
  always @(negedge clk) begin
    if (rst || !mem_we) begin
      pend = 1'b0;
    end else begin
      if (pend) chk("write_stable", {mem_addr, mem_wdata}, pend_v);
      if (mem_ready) begin
        pend = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {mem_addr, mem_wdata}, 40'h0);
        end else begin
          logic [39:0] e;
          e = exp_q.pop_front();
          chk("write_addr", 64'(mem_addr), 64'(e[39:32]));
          chk("write_data", 64'(mem_wdata), 64'(e[31:0]));
        end
      end else begin
        pend   = 1'b1;
        pend_v = {mem_addr, mem_wdata};
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic clr = 1'b0);
    byte_in    = b;
    byte_valid = 1'b1;
    clear_sign = clr;
    tick();
    byte_valid = 1'b0;
    clear_sign = 1'b0;
    tick(3);
  endtask

  task automatic pulse_clear();
    clear_sign = 1'b1;
    tick();
    clear_sign = 1'b0;
    tick(4);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tick();
  endtask

  task automatic check_status(input string tag, input logic hold, input logic done,
                              input logic [8:0] cnt, input logic [7:0] addr,
                              input logic ovr, input logic ferr);
    @(negedge clk);
    chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'(hold));
    chk({tag, "_load_done"}, 64'(load_done), 64'(done));
    chk({tag, "_word_count"}, 64'(word_count), 64'(cnt));
    chk({tag, "_addr"}, 64'(mem_addr), 64'(addr));
    chk({tag, "_overrun"}, 64'(overrun), 64'(ovr));
    chk({tag, "_full_err"}, 64'(full_err), 64'(ferr));
    tick();
  endtask

  task automatic check_reset(input string tag);
    @(negedge clk);
    chk({tag, "_we"}, 64'(mem_we), 64'h0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'h0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'h0);
    chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'h1);
    chk({tag, "_load_done"}, 64'(load_done), 64'h0);
    chk({tag, "_word_count"}, 64'(word_count), 64'h0);
    chk({tag, "_overrun"}, 64'(overrun), 64'h0);
    chk({tag, "_full_err"}, 64'(full_err), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; clear_sign = 1'b0;
    restart = 1'b0; mem_ready = 1'b1;
    tick(2);
    check_reset("reset");
    rst = 1'b0;
    tick();

    // Two full words, then clear with no partial word.
    exp_q.push_back({8'd0, 32'h01020304});
    exp_q.push_back({8'd1, 32'h05060708});
    for (int i = 1; i <= 8; i++) send(8'(i));
    pulse_clear();
    check_status("two_words", 1'b0, 1'b1, 9'd2, 8'd2, 1'b0, 1'b0);

    // Restart, then a padded partial word.
    do_restart();
    check_status("restart", 1'b1, 1'b0, 9'd0, 8'd0, 1'b0, 1'b0);
    exp_q.push_back({8'd0, 32'hAABB0000});
    send(8'hAA);
    send(8'hBB);
    pulse_clear();
    check_status("partial", 1'b0, 1'b1, 9'd1, 8'd1, 1'b0, 1'b0);

    // Stalled write: 11 parked, 22 dropped, 11 packed afterwards.
    do_restart();
    mem_ready = 1'b0;
    exp_q.push_back({8'd0, 32'h01020304});
    exp_q.push_back({8'd1, 32'h11000000});
    for (int i = 1; i <= 4; i++) send(8'(i));
    send(8'h11);
    send(8'h22);
    tick(10);
    check_status("stall", 1'b1, 1'b0, 9'd0, 8'd0, 1'b1, 1'b0);
    mem_ready = 1'b1;
    tick(4);
    pulse_clear();
    check_status("overrun", 1'b0, 1'b1, 9'd2, 8'd2, 1'b1, 1'b0);

    // Memory full after two words; remaining bytes dropped.
    do_restart();
    exp_q.push_back({8'd0, 32'h21222324});
    exp_q.push_back({8'd1, 32'h25262728});
    for (int i = 0; i < 12; i++) send(8'h21 + 8'(i));
    check_status("full", 1'b1, 1'b0, 9'd2, 8'd2, 1'b0, 1'b1);
    pulse_clear();
    check_status("full_done", 1'b0, 1'b1, 9'd2, 8'd2, 1'b0, 1'b1);

    // Stray clears in IDLE, then byte and clear together.
    do_restart();
    for (int i = 0; i < 3; i++) begin
      pulse_clear();
      check_status("idle_clear", 1'b1, 1'b0, 9'd0, 8'd0, 1'b0, 1'b0);
    end
    exp_q.push_back({8'd0, 32'h5A000000});
    send(8'h5A, 1'b1);
    tick(2);
    check_status("byte_and_clear", 1'b0, 1'b1, 9'd1, 8'd1, 1'b0, 1'b0);

    // Reset while a write is stalled.
    do_restart();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h61 + 8'(i));
    @(negedge clk);
    chk("midwrite_we", 64'(mem_we), 64'h1);
    chk("midwrite_wdata", 64'(mem_wdata), 64'h61626364);
    tick();
    rst = 1'b1;
    @(posedge clk);
    check_reset("midwrite_reset");
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;
    tick(3);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
